// File: rtl/dot_matrix_scanner_pkg.sv
// dot_matrix_scanner_pkg: shared matrix size, scan-state encoding and default slot timing.
package dot_matrix_scanner_pkg;
    localparam int N_LINES         = 8;
    localparam int ROW_W           = $clog2(N_LINES);
    localparam int ROW_TICKS_DEF   = 6250;
    localparam int BLANK_TICKS_DEF = 50;
    typedef enum logic {S_BLANK = 1'b0, S_DRIVE = 1'b1} scan_state_e;
endpackage

// File: rtl/dot_matrix_scanner_if.sv
// dot_matrix_scanner_if: map/enable inputs and row/column drive outputs.
// i_Bright is present only when DOT_MATRIX_DIM_EN is defined.
interface dot_matrix_scanner_if;
    import dot_matrix_scanner_pkg::*;
    logic [N_LINES*N_LINES-1:0] i_Map_Data;
    logic                       i_Enable;
`ifdef DOT_MATRIX_DIM_EN
    logic [1:0]                 i_Bright;
`endif
    logic [N_LINES-1:0]         o_Row;
    logic [N_LINES-1:0]         o_Col;
    logic                       o_Frame_Start;
    modport master (output i_Map_Data, output i_Enable,
`ifdef DOT_MATRIX_DIM_EN
                    output i_Bright,
`endif
                    input o_Row, input o_Col, input o_Frame_Start);
    modport slave  (input i_Map_Data, input i_Enable,
`ifdef DOT_MATRIX_DIM_EN
                    input i_Bright,
`endif
                    output o_Row, output o_Col, output o_Frame_Start);
endinterface

// File: rtl/dot_matrix_scanner_scan_timer.sv
// dot_matrix_scanner_scan_timer: blank/drive slot FSM with tick counter and row index.
module dot_matrix_scanner_scan_timer
    import dot_matrix_scanner_pkg::*;
#(
    parameter int ROW_TICKS   = ROW_TICKS_DEF,
    parameter int BLANK_TICKS = BLANK_TICKS_DEF,
    localparam int TW         = $clog2(ROW_TICKS)
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic              en_i,
    output scan_state_e       state_o,
    output logic [TW-1:0]     tick_o,
    output logic [ROW_W-1:0]  row_o
);
    scan_state_e      state_q, state_d;
    logic [TW-1:0]    tick_q, tick_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             blank_done, slot_done;

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state_q <= S_BLANK;
            tick_q  <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            row_q   <= row_d;
        end
    end

    // Disable parks the scanner at the start of row 0's blanking.
    always_comb begin
        blank_done = state_q == S_BLANK && tick_q == TW'(BLANK_TICKS - 1);
        slot_done  = state_q == S_DRIVE && tick_q == TW'(ROW_TICKS - 1);
        state_d    = !en_i ? S_BLANK : blank_done ? S_DRIVE : slot_done ? S_BLANK : state_q;
        tick_d     = (!en_i || slot_done) ? '0 : tick_q + 1'b1;
        row_d      = !en_i ? '0 : slot_done ? row_q + 1'b1 : row_q;
    end

    assign state_o = state_q;
    assign tick_o  = tick_q;
    assign row_o   = row_q;
endmodule

// File: rtl/dot_matrix_scanner.sv
// dot_matrix_scanner: tear-free 8x8 LED row scanner with per-row blanking and frame-start strobe.
// Optional DOT_MATRIX_DIM_EN adds i_Bright duty-cycle dimming within each drive window.
module dot_matrix_scanner
    import dot_matrix_scanner_pkg::*;
#(
    parameter int ROW_TICKS   = ROW_TICKS_DEF,
    parameter int BLANK_TICKS = BLANK_TICKS_DEF
) (
    input logic                 i_Clk,
    input logic                 i_Rst,
    dot_matrix_scanner_if.slave bus
);
    localparam int TW = $clog2(ROW_TICKS);

    scan_state_e                state;
    logic [TW-1:0]              tick;
    logic [ROW_W-1:0]           row;
    logic [N_LINES*N_LINES-1:0] buf_q, buf_d;
    logic [N_LINES-1:0]         row_q, row_d, col_q, col_d;
    logic                       frame_q, frame_d, lit;
`ifdef DOT_MATRIX_DIM_EN
    logic [1:0]                 bright_q, bright_d;
    logic [31:0]                drive_tick, lit_ticks;
`endif

    dot_matrix_scanner_scan_timer #(.ROW_TICKS(ROW_TICKS), .BLANK_TICKS(BLANK_TICKS)) u_timer (
        .i_Clk   (i_Clk),
        .i_Rst   (i_Rst),
        .en_i    (bus.i_Enable),
        .state_o (state),
        .tick_o  (tick),
        .row_o   (row)
    );

    // Outputs lag the timer by one cycle so every output comes straight from a flop.
    always_comb begin
        frame_d = bus.i_Enable && state == S_BLANK && tick == '0 && row == '0;
        buf_d   = frame_d ? bus.i_Map_Data : buf_q;
        lit     = bus.i_Enable && state == S_DRIVE;
`ifdef DOT_MATRIX_DIM_EN
        bright_d   = frame_d ? bus.i_Bright : bright_q;
        drive_tick = 32'(tick) - 32'(BLANK_TICKS);
        lit_ticks  = ((32'(bright_q) + 32'd1) * 32'(ROW_TICKS - BLANK_TICKS)) >> 2;
        lit        = lit && drive_tick < lit_ticks;
`endif
        row_d = lit ? N_LINES'(1) << row : '0;
        col_d = lit ? buf_q[row*N_LINES +: N_LINES] : '0;
    end

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            buf_q    <= '0;
            row_q    <= '0;
            col_q    <= '0;
            frame_q  <= 1'b0;
`ifdef DOT_MATRIX_DIM_EN
            bright_q <= '0;
`endif
        end else begin
            buf_q    <= buf_d;
            row_q    <= row_d;
            col_q    <= col_d;
            frame_q  <= frame_d;
`ifdef DOT_MATRIX_DIM_EN
            bright_q <= bright_d;
`endif
        end
    end

    assign bus.o_Row         = row_q;
    assign bus.o_Col         = col_q;
    assign bus.o_Frame_Start = frame_q;
endmodule

// File: doc/dot_matrix_scanner.md
Name: dot_matrix_scanner

Overview:
Downstream consumer of the game-logic block's 64-bit map output. Drives the 8x8 LED dot matrix by time-multiplexed row scanning.
- Snapshots the full map once per frame (tear-free).
- Scans rows 0..7 with a blanking gap before each row to suppress ghosting.
- Emits a frame-start strobe for display-side sync.

Parameters:
- ROW_TICKS, 6250, clock cycles per row slot including blanking (50 MHz → 8 kHz row rate, 1 kHz frame rate).
- BLANK_TICKS, 50, cycles at the start of each row slot with all rows and columns off. Constraint: 1 ≤ BLANK_TICKS < ROW_TICKS.

Ports:
- i_Clk  in  1  system clock, 50 MHz.
- i_Rst  in  1  reset, asynchronous, active-low.
- i_Map_Data  in  64  live map from game logic. Row r = bits [8r+7:8r]; row 0 = bits [7:0] = judgment (bottom) row.
- i_Enable  in  1  scan enable. Low forces the display dark and holds the scanner in its idle position.
- o_Row  out  8  one-hot row select, active-high; bit r drives row r.
- o_Col  out  8  column data, active-high; o_Col[c] = snapshot row bit c.
- o_Frame_Start  out  1  single-cycle pulse on the snapshot cycle.

Behaviour:
- Reset (async, i_Rst low):
  - o_Row = 0, o_Col = 0, o_Frame_Start = 0.
  - Row index = 0, state = S_BLANK, tick counter = 0, snapshot buffer = 0.
- Outputs: all registered. No combinational path from any input to any output.
- States:
  - S_BLANK: o_Row = 0, o_Col = 0. Lasts BLANK_TICKS cycles.
  - S_DRIVE: o_Row = 1 << row, o_Col = buffer[8·row+7 : 8·row]. Lasts ROW_TICKS − BLANK_TICKS cycles.
- Transitions:
  - S_BLANK → S_DRIVE when tick = BLANK_TICKS−1.
  - S_DRIVE → S_BLANK when tick = ROW_TICKS−1. The row index then increments mod 8 (7 wraps to 0) and the tick resets to 0.
- Snapshot:
  - Taken on the first cycle of S_BLANK for row 0: buffer ← i_Map_Data, o_Frame_Start = 1 for that one cycle.
  - Changes to i_Map_Data at any other time are not visible until the next frame.
- Latency: snapshot to first lit column is BLANK_TICKS cycles. Frame period = 8·ROW_TICKS cycles exactly.
- Timing invariants:
  - o_Row is never non-zero while the row index is changing.
  - Each row change is preceded by ≥ BLANK_TICKS dark cycles.
- i_Enable low (sampled synchronously):
  - Next cycle: o_Row = 0, o_Col = 0, o_Frame_Start = 0.
  - Row = 0, state = S_BLANK, tick = 0. Buffer is retained.
- i_Enable rising: the first enabled cycle is the row-0 snapshot cycle (o_Frame_Start pulses).
- Reset mid-row: immediate dark outputs. Scanning resumes from the row-0 snapshot after i_Rst deasserts.
- Map all zeros: the full scan still runs with o_Col = 0 and o_Row still cycling.

Optional Feature:
- Macro DOT_MATRIX_DIM_EN.
- Defined:
  - Adds input i_Bright, 2 bits.
  - Within S_DRIVE, outputs are gated: o_Row and o_Col are active only while drive_tick < ((i_Bright+1) · (ROW_TICKS−BLANK_TICKS)) >> 2, then forced 0 for the remainder of the slot.
  - i_Bright = 3 gives full brightness.
  - i_Bright is sampled at snapshot time and held for the frame.
- Undefined: no i_Bright port; full S_DRIVE duty.

Decomposition:
- Shared package holds:
  - Row/column count constant (8).
  - State encoding (S_BLANK = 0, S_DRIVE = 1).
  - Default ROW_TICKS/BLANK_TICKS constants.
- One natural sub-module, scan_timer:
  - Parameterised tick counter.
  - Produces blank_done / slot_done strobes and the row index.
- Top level owns the snapshot buffer, output muxing and dimming.

Test Plan (ROW_TICKS=10, BLANK_TICKS=2 unless noted):
1. Reset release, i_Enable=1, i_Map_Data=64'h8040201008040201 → o_Frame_Start pulses at cycle 0; cycles 2–9: o_Row=8'h01, o_Col=8'h01; cycles 12–19: o_Row=8'h02, o_Col=8'h02; …; row 7 shows o_Col=8'h80. Frame period = 80 cycles.
2. Change i_Map_Data to all-ones at cycle 35 (mid-frame) → o_Col keeps the old per-row values until cycle 80. From cycle 82 onward, o_Col=8'hFF in every drive window.
3. Over 3 frames, check every cycle: o_Row is 0 or one-hot; o_Row is 0 for exactly 2 cycles before each row change; never two rows active.
4. Deassert i_Enable at cycle 45 → o_Row=o_Col=0 from cycle 46. Reassert at cycle 60 → o_Frame_Start pulses on the first enabled cycle, and row 0 lights 2 cycles later.
5. Assert i_Rst low mid-drive of row 5 → outputs 0 immediately (async). After release, o_Frame_Start pulses and scanning restarts at row 0.
6. With DOT_MATRIX_DIM_EN, i_Bright=1, ROW_TICKS=10, BLANK_TICKS=2 → drive window of 8 cycles lit for 4 cycles. i_Bright=3 → lit for 8 cycles. i_Bright=0 → lit for 2 cycles.
